// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared state, source encodings and defaults for the memory access sequencer
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACCESS,
    XFER,
    RESP
  } state_t;

  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_LS = 1'b1;

  localparam int WAIT_CYCLES_DEF = 1;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester picker (IF/LS); MEM_RR_ARB_EN selects round-robin over fixed LS priority
module mem_arbiter
  import mem_ctrl_pkg::*;
(
`ifdef MEM_RR_ARB_EN
  input  logic clock,
  input  logic clear,
  input  logic grant_en,
`endif
  input  logic if_req,
  input  logic ls_req,
  output logic any_req,
  output logic grant_src
);

  assign any_req = if_req | ls_req;

`ifdef MEM_RR_ARB_EN
  logic last_grant;

  // Starts at LS so the very first contention goes to IF.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      last_grant <= SRC_LS;
    end else if (grant_en) begin
      last_grant <= grant_src;
    end
  end

  always_comb begin
    grant_src = SRC_IF;
    if (if_req && ls_req) begin
      grant_src = (last_grant == SRC_LS) ? SRC_IF : SRC_LS;
    end else if (ls_req) begin
      grant_src = SRC_LS;
    end
  end
`else
  always_comb begin
    grant_src = ls_req ? SRC_LS : SRC_IF;
  end
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MAR/MDR/RAM access sequencer shared by fetch and load/store; MEM_RR_ARB_EN enables round-robin
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic if_req,
  output logic if_ack,
  input  logic ls_req,
  input  logic ls_we,
  output logic ls_ack,
  output logic PCout,
  output logic EAout,
  output logic MARin,
  output logic mem_read,
  output logic mem_write,
  output logic MDRin,
  output logic mdr_read,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             src, src_n;
  logic             we, we_n;
  logic             any_req, grant_src, grant_en;

  mem_arbiter u_arb (
`ifdef MEM_RR_ARB_EN
    .clock    (clock),
    .clear    (clear),
    .grant_en (grant_en),
`endif
    .if_req   (if_req),
    .ls_req   (ls_req),
    .any_req  (any_req),
    .grant_src(grant_src)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      src   <= SRC_IF;
      we    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      src   <= src_n;
      we    <= we_n;
    end
  end

  // Outputs depend only on registered state/src/we; inputs feed next-state only.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    src_n     = src;
    we_n      = we;
    grant_en  = 1'b0;
    if_ack    = 1'b0;
    ls_ack    = 1'b0;
    PCout     = 1'b0;
    EAout     = 1'b0;
    MARin     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    MDRin     = 1'b0;
    mdr_read  = 1'b0;
    busy      = (state != IDLE);

    case (state)
      IDLE: begin
        if (any_req) begin
          grant_en = 1'b1;
          src_n    = grant_src;
          we_n     = (grant_src == SRC_LS) && ls_we;
          state_n  = ADDR;
        end
      end
      ADDR: begin
        MARin   = 1'b1;
        PCout   = (src == SRC_IF);
        EAout   = (src == SRC_LS);
        cnt_n   = CNT_LOAD;
        state_n = (WAIT_CYCLES == 0) ? XFER : ACCESS;
      end
      ACCESS: begin
        mem_read  = ~we;
        mem_write = we;
        cnt_n     = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_n = XFER;
        end
      end
      XFER: begin
        mem_read  = ~we;
        mem_write = we;
        MDRin     = ~we;
        mdr_read  = ~we;
        state_n   = RESP;
      end
      RESP: begin
        if_ack  = (src == SRC_IF);
        ls_ack  = (src == SRC_LS);
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl (WAIT_CYCLES=2 and 0 instances)
module tb_mem_access_ctrl;

  localparam int WA = 2;
  localparam int WB = 0;

  logic       clock;
  logic [1:0] clear_v;
  logic [1:0] ifr, lsr, lsw;
  logic [9:0] oa, ob;

  int n_cmp;
  int n_err;

  // bit order: busy, if_ack, ls_ack, PCout, EAout, MARin, mem_read, mem_write, MDRin, mdr_read
  mem_access_ctrl #(.WAIT_CYCLES(WA), .CNT_W(4)) dut_a (
    .clock(clock), .clear(clear_v[0]),
    .if_req(ifr[0]), .if_ack(oa[8]),
    .ls_req(lsr[0]), .ls_we(lsw[0]), .ls_ack(oa[7]),
    .PCout(oa[6]), .EAout(oa[5]), .MARin(oa[4]),
    .mem_read(oa[3]), .mem_write(oa[2]), .MDRin(oa[1]), .mdr_read(oa[0]),
    .busy(oa[9])
  );

  mem_access_ctrl #(.WAIT_CYCLES(WB), .CNT_W(4)) dut_b (
    .clock(clock), .clear(clear_v[1]),
    .if_req(ifr[1]), .if_ack(ob[8]),
    .ls_req(lsr[1]), .ls_we(lsw[1]), .ls_ack(ob[7]),
    .PCout(ob[6]), .EAout(ob[5]), .MARin(ob[4]),
    .mem_read(ob[3]), .mem_write(ob[2]), .MDRin(ob[1]), .mdr_read(ob[0]),
    .busy(ob[9])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] obs(input int i);
    return (i != 0) ? ob : oa;
  endfunction

  // Expected outputs k cycles into a transaction: 1=address, then w access cycles, transfer, response.
  function automatic logic [9:0] exp_vec(input int k, input logic s, input logic wr, input int w);
    logic [9:0] v;
    v = '0;
    if (k >= 1) v[9] = 1'b1;
    if (k == 1) begin
      v[4] = 1'b1;
      if (s) v[5] = 1'b1;
      else   v[6] = 1'b1;
    end
    if (k >= 2 && k <= w + 1) begin
      if (wr) v[2] = 1'b1;
      else    v[3] = 1'b1;
    end
    if (k == w + 2) begin
      if (wr) v[2] = 1'b1;
      else    v[3:0] = 4'b1011;
    end
    if (k == w + 3) begin
      if (s) v[7] = 1'b1;
      else   v[8] = 1'b1;
    end
    return v;
  endfunction

  task automatic run(input int idx, input int ncyc, input bit do_clr);
    int   w, kk;
    logic src, we, last;
    bit   clr_done;
    w = (idx != 0) ? WB : WA;
    kk = 0; src = 1'b0; we = 1'b0; last = 1'b1; clr_done = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      chk($sformatf("dut%0d_cyc%0d_k%0d", idx, c, kk), obs(idx), exp_vec(kk, src, we, w));

      if (do_clr && !clr_done && c > 60 && kk == 2) begin
        clear_v[idx] = 1'b1;
        #1;
        chk("async_clear", obs(idx), 10'd0);
        ifr[idx] = 1'b0;
        lsr[idx] = 1'b0;
        @(posedge clock);
        #1;
        chk("clear_held", obs(idx), 10'd0);
        @(negedge clock);
        clear_v[idx] = 1'b0;
        kk = 0; last = 1'b1; clr_done = 1'b1;
        continue;
      end

      if (kk == w + 3) begin
        if (src) lsr[idx] = 1'b0;
        else     ifr[idx] = 1'b0;
      end else if (kk >= 1 && $urandom_range(3) == 0) begin
        if (src) lsr[idx] = 1'b0;
        else     ifr[idx] = 1'b0;
      end
      if (!(kk >= 1 && src == 1'b0) && !ifr[idx] && $urandom_range(2) == 0) ifr[idx] = 1'b1;
      if (!(kk >= 1 && src == 1'b1) && !lsr[idx] && $urandom_range(2) == 0) lsr[idx] = 1'b1;
      lsw[idx] = 1'($urandom_range(1));

      if (kk == 0) begin
        if (ifr[idx] || lsr[idx]) begin
`ifdef MEM_RR_ARB_EN
          if (ifr[idx] && lsr[idx]) src = ~last;
          else                      src = lsr[idx];
`else
          src = lsr[idx];
`endif
          last = src;
          we = src & lsw[idx];
          kk = 1;
        end
      end else if (kk == w + 3) begin
        kk = 0;
      end else begin
        kk++;
      end
    end
    ifr[idx] = 1'b0;
    lsr[idx] = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_v = 2'b11;
    ifr = '0;
    lsr = '0;
    lsw = '0;
    #1;
    chk("reset_a", oa, 10'd0);
    chk("reset_b", ob, 10'd0);
    repeat (3) @(negedge clock);
    chk("reset_a_held", oa, 10'd0);
    chk("reset_b_held", ob, 10'd0);
    clear_v = 2'b00;
    run(0, 500, 1'b1);
    run(1, 400, 1'b0);
    repeat (4) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
